// File: rtl/cam_tx_pkg.sv
// rtl/cam_tx_pkg.sv - shared FSM type, pattern codes, bar colours and byte split for cam_tx
package cam_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } cam_state_t;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_SOLID = 2'd1;
  localparam logic [1:0] PAT_GRAD  = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  localparam int BAR_W = 20;

  localparam logic [11:0] BAR_RGB [0:7] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  // Even byte carries red in the low nibble, odd byte carries green/blue.
  function automatic logic [7:0] rgb444_byte(input logic [11:0] rgb, input logic odd);
    return odd ? rgb[7:0] : {4'h0, rgb[11:8]};
  endfunction

endpackage

// File: rtl/cam_pattern_rgb.sv
// rtl/cam_pattern_rgb.sv - combinational test-pattern colour for one pixel
module cam_pattern_rgb
  import cam_tx_pkg::*;
(
  input  logic [7:0]  i_x,
  input  logic [3:0]  i_y_blk,
  input  logic [1:0]  i_pattern,
  input  logic [11:0] i_solid_rgb,
  output logic [11:0] o_rgb
);

  logic [7:0] w_bar;

  assign w_bar = i_x / 8'(BAR_W);

  // i_y_blk is y/8: gradient green and checker rows both step every 8 lines.
  always_comb begin
    o_rgb = 12'h000;
    case (i_pattern)
      PAT_BARS:  o_rgb = (w_bar > 8'd7) ? 12'h000 : BAR_RGB[w_bar[2:0]];
      PAT_SOLID: o_rgb = i_solid_rgb;
      PAT_GRAD:  o_rgb = {i_x[7:4], i_y_blk, 4'h8};
      PAT_CHECK: o_rgb = (i_x[3] ^ i_y_blk[0]) ? 12'hFFF : 12'h000;
      default:   o_rgb = 12'h000;
    endcase
  end

endmodule

// File: rtl/cam_tx.sv
// rtl/cam_tx.sv - OV7670-style pixel bus generator (pclk, vsync, href, RGB444 bytes)
module cam_tx
  import cam_tx_pkg::*;
#(
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120,
  parameter int H_BLANK      = 16,
  parameter int VS_LINES     = 3,
  parameter int VBP_LINES    = 2,
  parameter int VFP_LINES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern,
  input  logic [11:0] solid_rgb,
  output logic        CAM_pclk,
  output logic        CAM_vsync,
  output logic        CAM_href,
  output logic [7:0]  CAM_px_data,
  output logic        frame_done
);

  localparam int         LINE      = 2 * CAM_SCREEN_X + H_BLANK;
  localparam logic [8:0] BCNT_LAST = 9'(LINE - 1);
  localparam logic [8:0] ACT_BYTES = 9'(2 * CAM_SCREEN_X);

  cam_state_t  r_state;
  cam_state_t  w_state_nx;
  logic        r_pclk;
  logic        r_vsync;
  logic        r_href;
  logic        r_frame_done;
  logic [7:0]  r_px_data;
  logic [8:0]  r_bcnt;
  logic [8:0]  w_bcnt_nx;
  logic [6:0]  r_lcnt;
  logic [6:0]  w_lcnt_nx;
  logic [6:0]  w_lines_last;
  logic [1:0]  r_pattern;
  logic [11:0] r_solid;
  logic        w_latch;
  logic        w_done_nx;
  logic        w_href_nx;
  logic [7:0]  w_data_nx;
  logic [11:0] w_rgb;

  always_comb begin
    case (r_state)
      ST_VSYNC:  w_lines_last = 7'(VS_LINES - 1);
      ST_VBP:    w_lines_last = 7'(VBP_LINES - 1);
      ST_ACTIVE: w_lines_last = 7'(CAM_SCREEN_Y - 1);
      default:   w_lines_last = 7'(VFP_LINES - 1);
    endcase
  end

  // Next-tick state and counters; the registered outputs are derived from these
  // so href and data move together with the counters on the same fall tick.
  always_comb begin
    w_state_nx = r_state;
    w_bcnt_nx  = r_bcnt;
    w_lcnt_nx  = r_lcnt;
    w_latch    = 1'b0;
    w_done_nx  = 1'b0;
    if (r_state == ST_IDLE) begin
      w_bcnt_nx = '0;
      w_lcnt_nx = '0;
      if (en) begin
        w_state_nx = ST_VSYNC;
        w_latch    = 1'b1;
      end
    end else if (r_bcnt != BCNT_LAST) begin
      w_bcnt_nx = r_bcnt + 9'd1;
    end else begin
      w_bcnt_nx = '0;
      if (r_lcnt != w_lines_last) begin
        w_lcnt_nx = r_lcnt + 7'd1;
      end else begin
        w_lcnt_nx = '0;
        case (r_state)
          ST_VSYNC:  w_state_nx = ST_VBP;
          ST_VBP:    w_state_nx = ST_ACTIVE;
          ST_ACTIVE: w_state_nx = ST_VFP;
          default: begin
            w_done_nx = 1'b1;
            if (en) begin
              w_state_nx = ST_VSYNC;
              w_latch    = 1'b1;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  cam_pattern_rgb u_pattern (
    .i_x         (w_bcnt_nx[8:1]),
    .i_y_blk     (w_lcnt_nx[6:3]),
    .i_pattern   (r_pattern),
    .i_solid_rgb (r_solid),
    .o_rgb       (w_rgb)
  );

  assign w_href_nx = (w_state_nx == ST_ACTIVE) && (w_bcnt_nx < ACT_BYTES);
  assign w_data_nx = w_href_nx ? rgb444_byte(w_rgb, w_bcnt_nx[0]) : 8'h00;

  // r_pclk == 1 before the edge marks a fall tick: everything else advances then.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pclk       <= 1'b0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_px_data    <= 8'h00;
      r_frame_done <= 1'b0;
      r_bcnt       <= '0;
      r_lcnt       <= '0;
      r_pattern    <= PAT_BARS;
      r_solid      <= 12'h000;
    end else begin
      r_pclk       <= ~r_pclk;
      r_frame_done <= 1'b0;
      if (r_pclk) begin
        r_state      <= w_state_nx;
        r_bcnt       <= w_bcnt_nx;
        r_lcnt       <= w_lcnt_nx;
        r_vsync      <= (w_state_nx == ST_VSYNC);
        r_href       <= w_href_nx;
        r_px_data    <= w_data_nx;
        r_frame_done <= w_done_nx;
        if (w_latch) begin
          r_pattern <= pattern;
          r_solid   <= solid_rgb;
        end
      end
    end
  end

  assign CAM_pclk    = r_pclk;
  assign CAM_vsync   = r_vsync;
  assign CAM_href    = r_href;
  assign CAM_px_data = r_px_data;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_cam_tx.sv
// tb/tb_cam_tx.sv - frame-model and vector checks for cam_tx (reduced frame height)
`timescale 1ns/1ps
module tb_cam_tx;

  localparam int X     = 160;
  localparam int Y     = 12;
  localparam int HB    = 16;
  localparam int VS    = 3;
  localparam int VBP   = 2;
  localparam int VFP   = 2;
  localparam int LINE  = 2 * X + HB;
  localparam int FRAME = (VS + VBP + Y + VFP) * LINE;

  localparam logic [11:0] BARS [0:7] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [1:0]  pattern = 2'd0;
  logic [11:0] solid_rgb = 12'h000;
  logic        CAM_pclk;
  logic        CAM_vsync;
  logic        CAM_href;
  logic [7:0]  CAM_px_data;
  logic        frame_done;

  cam_tx #(
    .CAM_SCREEN_X (X),
    .CAM_SCREEN_Y (Y),
    .H_BLANK      (HB),
    .VS_LINES     (VS),
    .VBP_LINES    (VBP),
    .VFP_LINES    (VFP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pattern     (pattern),
    .solid_rgb   (solid_rgb),
    .CAM_pclk    (CAM_pclk),
    .CAM_vsync   (CAM_vsync),
    .CAM_href    (CAM_href),
    .CAM_px_data (CAM_px_data),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         fid;
    int         x;
    int         y;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;

  vec_t       vecs [12];
  logic [7:0] cap [0:Y-1][0:2*X-1];
  int         n_checks = 0;
  int         n_fail = 0;
  int         fd_count = 0;

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input int pat, input logic [11:0] solid,
                                            input int x, input int y);
    case (pat)
      0:       return BARS[x / 20];
      1:       return solid;
      2:       return {4'((x / 16) % 16), 4'((y / 8) % 16), 4'h8};
      default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  function automatic logic [7:0] model_byte(input int pat, input logic [11:0] solid,
                                            input int b, input int y);
    logic [11:0] c;
    c = model_rgb(pat, solid, b / 2, y);
    return (b % 2 == 1) ? c[7:0] : {4'h0, c[11:8]};
  endfunction

  // Advance to the next pclk sampling point (negedge clk just after pclk rose).
  task automatic next_sample();
    @(negedge clk);
    if (CAM_pclk !== 1'b1) @(negedge clk);
  endtask

  task automatic wait_start(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      next_sample();
      if (CAM_vsync === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic capture(input int fid, input int pat, input logic [11:0] solid,
                         input int act_k, input logic [1:0] n_pat,
                         input logic [11:0] n_solid, input logic n_en);
    int         mism;
    int         pulses;
    int         bad_w;
    int         run;
    int         line;
    int         b;
    logic       ok;
    logic       ev;
    logic       eh;
    logic [7:0] ed;
    mism = 0; pulses = 0; bad_w = 0; run = 0;
    wait_start(ok);
    check($sformatf("frame%0d_start", fid), 32'(ok), 1);
    if (!ok) return;
    for (int k = 0; k < FRAME; k++) begin
      line = k / LINE;
      b    = k % LINE;
      ev   = (line < VS);
      eh   = (line >= VS + VBP) && (line < VS + VBP + Y) && (b < 2 * X);
      ed   = eh ? model_byte(pat, solid, b, line - VS - VBP) : 8'h00;
      if (CAM_vsync !== ev || CAM_href !== eh || CAM_px_data !== ed) mism++;
      if (k != 0 && frame_done !== 1'b0) mism++;
      if (eh) cap[line - VS - VBP][b] = CAM_px_data;
      if (CAM_href === 1'b1) run++;
      else if (run != 0) begin
        pulses++;
        if (run != 2 * X) bad_w++;
        run = 0;
      end
      if (k == act_k) begin
        pattern   = n_pat;
        solid_rgb = n_solid;
        en        = n_en;
      end
      if (k != FRAME - 1) next_sample();
    end
    check($sformatf("frame%0d_bad_samples", fid), mism, 0);
    check($sformatf("frame%0d_href_pulses", fid), pulses, Y);
    check($sformatf("frame%0d_href_bad_width", fid), bad_w, 0);
  endtask

  task automatic apply_vecs(input int fid);
    foreach (vecs[i]) begin
      if (vecs[i].fid == fid) begin
        check($sformatf("frame%0d_px(%0d,%0d)_even", fid, vecs[i].x, vecs[i].y),
              32'(cap[vecs[i].y][2 * vecs[i].x]), 32'(vecs[i].b0));
        check($sformatf("frame%0d_px(%0d,%0d)_odd", fid, vecs[i].x, vecs[i].y),
              32'(cap[vecs[i].y][2 * vecs[i].x + 1]), 32'(vecs[i].b1));
      end
    end
  endtask

  initial begin
    logic [11:0] rnd_solid;
    logic [11:0] rnd_solid2;
    logic [1:0]  rnd_pat;
    logic        ok;
    int          stray;

    vecs[0]  = '{0, 0,   0,  8'h0F, 8'hFF};
    vecs[1]  = '{0, 20,  0,  8'h0F, 8'hF0};
    vecs[2]  = '{0, 159, 0,  8'h00, 8'h00};
    vecs[3]  = '{0, 59,  7,  8'h00, 8'hFF};
    vecs[4]  = '{1, 0,   0,  8'h00, 8'h00};
    vecs[5]  = '{1, 8,   0,  8'h0F, 8'hFF};
    vecs[6]  = '{1, 8,   8,  8'h00, 8'h00};
    vecs[7]  = '{2, 37,  5,  8'h0A, 8'h5C};
    vecs[8]  = '{2, 159, 11, 8'h0A, 8'h5C};
    vecs[9]  = '{3, 100, 9,  8'h06, 8'h18};
    vecs[10] = '{3, 159, 11, 8'h09, 8'h18};
    vecs[11] = '{3, 0,   0,  8'h00, 8'h08};

    rst = 1'b1; en = 1'b1; pattern = 2'd0; solid_rgb = 12'h000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("reset_outputs", 32'({CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done}), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("vsync_after_edge1", 32'(CAM_vsync), 0);
    @(posedge clk); #1;
    check("vsync_after_edge2", 32'(CAM_vsync), 1);

    capture(0, 0, 12'h000, 10 * LINE + 5, 2'd3, 12'h000, 1'b1);
    apply_vecs(0);
    capture(1, 3, 12'h000, 10 * LINE + 5, 2'd1, 12'hA5C, 1'b1);
    apply_vecs(1);
    rnd_solid = 12'($urandom);
    capture(2, 1, 12'hA5C, 10 * LINE + 5, 2'd2, rnd_solid, 1'b1);
    apply_vecs(2);
    capture(3, 2, rnd_solid, (VS + VBP + 6) * LINE + 7, 2'd2, rnd_solid, 1'b0);
    apply_vecs(3);

    stray = 0;
    for (int i = 0; i < 2 * LINE; i++) begin
      next_sample();
      if (CAM_vsync !== 1'b0 || CAM_href !== 1'b0) stray++;
    end
    check("idle_after_en_low", stray, 0);
    check("frame_done_pulses", fd_count, 4);

    rnd_pat    = 2'($urandom_range(0, 3));
    rnd_solid2 = 12'($urandom);
    pattern    = rnd_pat;
    solid_rgb  = rnd_solid2;
    en         = 1'b1;
    wait_start(ok);
    check("restart_vsync", 32'(ok), 1);
    for (int k = 0; k < (VS + VBP) * LINE + 100; k++) next_sample();
    check("href_before_reset", 32'(CAM_href), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_href", 32'(CAM_href), 0);
    check("rst_data", 32'(CAM_px_data), 0);
    check("rst_vsync_pclk", 32'({CAM_vsync, CAM_pclk, frame_done}), 0);
    @(posedge clk); #1;
    check("rst_hold_outputs", 32'({CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done}), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("restart_vsync_edge1", 32'(CAM_vsync), 0);
    @(posedge clk); #1;
    check("restart_vsync_edge2", 32'(CAM_vsync), 1);
    capture(4, int'(rnd_pat), rnd_solid2, -1, 2'd0, 12'h000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
